// File: rtl/scs8hd_patgen_pkg.sv
// Shared types and constants for the nor4bb-family pattern generator.
// Imported by the timer and the top-level checker.
package scs8hd_patgen_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_t;

    localparam int          VEC_W        = 4;
    localparam int          TMR_W        = 4;
    localparam logic [15:0] NOR4BB_TRUTH = 16'h1000;

    // Saturating increment used by the error counter.
    function automatic logic [31:0] sat_inc(
        input logic [31:0] val,
        input logic [31:0] max
    );
        return (val >= max) ? max : val + 32'd1;
    endfunction

endpackage

// File: rtl/scs8hd_patgen_timer.sv
// Loadable down-counter that paces how long each vector is held.
// Counts down to zero and parks there until reloaded.
module scs8hd_patgen_timer
    import scs8hd_patgen_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [TMR_W-1:0] value,
    output logic             zero
);

    logic [TMR_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/scs8hd_nor4bb_patgen.sv
// Sweeps all 16 {DN,CN,B,A} vectors into a cell and checks Y against TRUTH.
// Define SCS8HD_PATGEN_FAILLOG_EN to add the first-failure log (fail_idx/fail_y).
module scs8hd_nor4bb_patgen
    import scs8hd_patgen_pkg::*;
#(
    parameter logic [15:0] TRUTH  = NOR4BB_TRUTH,
    parameter int          SETTLE = 2,
    parameter int          PASSES = 1,
    parameter int          CNT_W  = 6
) (
    input  logic             CLK,
    input  logic             RESETB,
    input  logic             start,
    input  logic             abort,
    input  logic             Y_obs,
    output logic             A,
    output logic             B,
    output logic             CN,
    output logic             DN,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt
`ifdef SCS8HD_PATGEN_FAILLOG_EN
    ,
    output logic [3:0]       fail_idx,
    output logic [0:0]       fail_y
`endif
);

    localparam logic [TMR_W-1:0] SETTLE_LD  = TMR_W'(SETTLE - 1);
    localparam logic [3:0]       LAST_SWEEP = 4'(PASSES - 1);
    localparam logic [31:0]      ERR_MAX    = 32'((64'd1 << CNT_W) - 1);

    state_t           state;
    state_t           state_nxt;
    logic [VEC_W-1:0] vec;
    logic [VEC_W-1:0] vec_nxt;
    logic [3:0]       sweep;
    logic [3:0]       sweep_nxt;
    logic [CNT_W-1:0] err_nxt;
    logic             y_q;
    logic             tmr_load;
    logic             tmr_zero;
    logic             miss;
    logic             launch;

    scs8hd_patgen_timer u_timer (
        .clk   (CLK),
        .rst_n (RESETB),
        .load  (tmr_load),
        .value (SETTLE_LD),
        .zero  (tmr_zero)
    );

    assign launch = start && !abort
                 && ((state == IDLE) || (state == DONE));
    assign miss   = (state == SAMPLE) && (y_q != TRUTH[vec]);

    always_comb begin
        state_nxt = state;
        vec_nxt   = vec;
        sweep_nxt = sweep;
        err_nxt   = err_cnt;
        tmr_load  = 1'b0;
        if (abort) begin
            state_nxt = IDLE;
            vec_nxt   = '0;
            sweep_nxt = '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state_nxt = DRIVE;
                        vec_nxt   = '0;
                        sweep_nxt = '0;
                        err_nxt   = '0;
                        tmr_load  = 1'b1;
                    end
                end
                DRIVE: begin
                    if (tmr_zero) begin
                        state_nxt = SAMPLE;
                    end
                end
                SAMPLE: begin
                    if (miss) begin
                        err_nxt = CNT_W'(sat_inc(32'(err_cnt), ERR_MAX));
                    end
                    if (vec != '1) begin
                        vec_nxt   = vec + 1'b1;
                        state_nxt = DRIVE;
                        tmr_load  = 1'b1;
                    end else if (sweep != LAST_SWEEP) begin
                        vec_nxt   = '0;
                        sweep_nxt = sweep + 1'b1;
                        state_nxt = DRIVE;
                        tmr_load  = 1'b1;
                    end else begin
                        vec_nxt   = '0;
                        state_nxt = DONE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            state   <= IDLE;
            vec     <= '0;
            sweep   <= '0;
            err_cnt <= '0;
            y_q     <= 1'b0;
        end else begin
            state   <= state_nxt;
            vec     <= vec_nxt;
            sweep   <= sweep_nxt;
            err_cnt <= err_nxt;
            // Last capture before SAMPLE is the one compared.
            if (state == DRIVE) begin
                y_q <= Y_obs;
            end
        end
    end

`ifdef SCS8HD_PATGEN_FAILLOG_EN
    logic fail_seen;

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            fail_seen <= 1'b0;
            fail_idx  <= '0;
            fail_y    <= '0;
        end else if (launch) begin
            fail_seen <= 1'b0;
            fail_idx  <= '0;
            fail_y    <= '0;
        end else if (miss && !fail_seen && !abort) begin
            fail_seen <= 1'b1;
            fail_idx  <= vec;
            fail_y    <= y_q;
        end
    end
`endif

    // The vector register is the stimulus, so pins only move on advance.
    assign A    = vec[0];
    assign B    = vec[1];
    assign CN   = vec[2];
    assign DN   = vec[3];
    assign busy = (state == DRIVE) || (state == SAMPLE);
    assign done = (state == DONE);
    assign pass = done && (err_cnt == '0);

endmodule

// File: tb/tb_scs8hd_nor4bb_patgen.sv
// Bench for scs8hd_nor4bb_patgen: per-cycle model compare plus directed literals.
// Build with SCS8HD_PATGEN_FAILLOG_EN to also check the failure log.
module tb_scs8hd_nor4bb_patgen;

    localparam int S   = 2;
    localparam int P   = 1;
    localparam int VT  = S + 1;
    localparam int RUN = 16 * P * VT;

    logic clk   = 1'b0;
    logic rstn  = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic y;
    logic a, b, cn, dn, busy, done, pass;
    logic [5:0] err;
    int ymode = 0;

    logic start1 = 1'b0;
    logic a1, b1, cn1, dn1, busy1, done1, pass1;
    logic [3:0] err1;

    int tests = 0;
    int fails = 0;

`ifdef SCS8HD_PATGEN_FAILLOG_EN
    logic [3:0] fidx, fidx1;
    logic [0:0] fy, fy1;
`endif

    always #5 clk = ~clk;

    // 0: ideal nor4bb cell, 1: stuck at 0, 2: stuck at 1
    assign y = (ymode == 0) ? (~a & ~b & cn & dn) : (ymode == 2);

    scs8hd_nor4bb_patgen u0 (
        .CLK(clk), .RESETB(rstn), .start(start), .abort(abort),
        .Y_obs(y), .A(a), .B(b), .CN(cn), .DN(dn),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err)
`ifdef SCS8HD_PATGEN_FAILLOG_EN
        , .fail_idx(fidx), .fail_y(fy)
`endif
    );

    scs8hd_nor4bb_patgen #(.PASSES(3), .CNT_W(4)) u1 (
        .CLK(clk), .RESETB(rstn), .start(start1), .abort(1'b0),
        .Y_obs(1'b1), .A(a1), .B(b1), .CN(cn1), .DN(dn1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1)
`ifdef SCS8HD_PATGEN_FAILLOG_EN
        , .fail_idx(fidx1), .fail_y(fy1)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: time since start decides vector and completion.
    bit m_busy, m_done, m_fseen;
    int m_t, m_err, m_fidx, m_fy, m_k;

    function automatic int m_vec();
        return m_busy ? (m_t / VT) % 16 : 0;
    endfunction

    function automatic int cell_y(int k);
        if (ymode == 0) return (k == 12) ? 1 : 0;
        return (ymode == 2) ? 1 : 0;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_busy = 0; m_done = 0; m_t = 0; m_err = 0;
            m_fseen = 0; m_fidx = 0; m_fy = 0;
        end else if (abort) begin
            m_busy = 0; m_done = 0;
        end else if (start && !m_busy) begin
            m_busy = 1; m_done = 0; m_t = 0; m_err = 0;
            m_fseen = 0; m_fidx = 0; m_fy = 0;
        end else if (m_busy) begin
            m_t++;
            if (m_t % VT == 0) begin
                m_k = (m_t / VT - 1) % 16;
                if (cell_y(m_k) != ((m_k == 12) ? 1 : 0)) begin
                    if (m_err < 63) m_err++;
                    if (!m_fseen) begin
                        m_fseen = 1; m_fidx = m_k; m_fy = cell_y(m_k);
                    end
                end
                if (m_t == RUN) begin
                    m_busy = 0; m_done = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("stim", {dn, cn, b, a}, 32'(m_vec()));
        chk("busy", busy, 32'(m_busy));
        chk("done", done, 32'(m_done));
        chk("pass", pass, 32'(m_done && m_err == 0));
        chk("err_cnt", err, 32'(m_err));
`ifdef SCS8HD_PATGEN_FAILLOG_EN
        chk("fail_idx", fidx, 32'(m_fidx));
        chk("fail_y", fy, 32'(m_fy));
`endif
    end

    task automatic wait_done(input int n0, input int limit, output int n);
        n = n0;
        while (!done && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        chk("rst_stim", {dn, cn, b, a}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        rstn = 1'b1;
        @(negedge clk);

        // Ideal cell, with a stray start mid-run
        ymode = 0;
        pulse_start();
        repeat (3) @(negedge clk);
        chk("t1_vec1", {dn, cn, b, a}, 4'b0001);
        repeat (33) @(negedge clk);
        chk("t1_vec12", {dn, cn, b, a}, 4'b1100);
        pulse_start();
        wait_done(37, 200, n);
        chk("t1_latency", n, 48);
        chk("t1_pass", pass, 1);
        chk("t1_err", err, 0);

        // start+abort together in DONE
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("t5_done", done, 0);
        chk("t5_busy", busy, 0);

        // Stuck at 0: only vector 12 mismatches
        ymode = 1;
        pulse_start();
        wait_done(0, 200, n);
        chk("t2_err", err, 1);
        chk("t2_pass", pass, 0);
`ifdef SCS8HD_PATGEN_FAILLOG_EN
        chk("t2_fidx", fidx, 12);
        chk("t2_fy", fy, 0);
`endif

        // Abort at vector 7 with stuck-at-1
        ymode = 2;
        pulse_start();
        repeat (21) @(negedge clk);
        chk("t4_at_vec7", {dn, cn, b, a}, 4'd7);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t4_busy", busy, 0);
        chk("t4_stim", {dn, cn, b, a}, 0);
        chk("t4_done", done, 0);
        chk("t4_err_kept", err, 7);
        ymode = 0;
        pulse_start();
        chk("t4_err_clr", err, 0);
        chk("t4_restart", busy, 1);
        wait_done(0, 200, n);
        chk("t4_pass", pass, 1);

        // Asynchronous reset mid-DRIVE
        ymode = 2;
        pulse_start();
        repeat (10) @(negedge clk);
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("t6_stim", {dn, cn, b, a}, 0);
        chk("t6_busy", busy, 0);
        chk("t6_err", err, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Saturation: 3 sweeps, 4-bit counter, Y stuck at 1
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        n = 0;
        while (!done1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("t3_latency", n, 144);
        chk("t3_err", err1, 15);
        chk("t3_pass", pass1, 0);
        chk("t3_idle", {busy1, dn1, cn1, b1, a1}, 0);
`ifdef SCS8HD_PATGEN_FAILLOG_EN
        chk("t3_fidx", fidx1, 0);
        chk("t3_fy", fy1, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
